// File: rtl/shift_seq_ctrl.sv
// Sequencer for an LED shift register: synchronised buttons drive a run/pause FSM,
// a prescaler paces o_step pulses and o_pos tracks the lit LED, with optional bounce.
module shift_seq_ctrl #(
    parameter int N_LEDS   = 4,
    parameter int NB_COUNT = 32,
    parameter int NB_SW    = 4
) (
    input  logic                        clock,
    input  logic                        i_reset,
    input  logic [NB_SW-1:0]            i_sw,
    input  logic [3:0]                  i_btn,
    output logic                        o_step,
    output logic                        o_dir,
    output logic                        o_load,
    output logic [N_LEDS-1:0]           o_seed,
    output logic [1:0]                  o_state,
    output logic [$clog2(N_LEDS)-1:0]   o_pos,
    output logic                        o_bounce
);

    localparam int POS_W = $clog2(N_LEDS);
    localparam logic [POS_W-1:0]    POS_MAX = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0]    POS_ONE = POS_W'(1);
    localparam logic [POS_W-1:0]    POS_ZERO = {POS_W{1'b0}};
    localparam logic [NB_COUNT-1:0] LIM0 = NB_COUNT'((64'd1 << (NB_COUNT - 10)) - 64'd1);
    localparam logic [NB_COUNT-1:0] LIM1 = NB_COUNT'((64'd1 << (NB_COUNT - 9)) - 64'd1);
    localparam logic [NB_COUNT-1:0] LIM2 = NB_COUNT'((64'd1 << (NB_COUNT - 8)) - 64'd1);
    localparam logic [NB_COUNT-1:0] LIM3 = NB_COUNT'((64'd1 << (NB_COUNT - 7)) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN_L = 2'd1,
        ST_RUN_R = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_sync1;
    logic [3:0]            r_sync2;
    logic [3:0]            r_prev;
    logic [1:0]            r_arm;
    logic [3:0]            w_ev;
    logic [NB_COUNT-1:0]   r_count;
    logic [NB_COUNT-1:0]   w_count_nxt;
    logic [NB_COUNT-1:0]   w_limit;
    logic [POS_W-1:0]      r_pos;
    logic [POS_W-1:0]      w_pos_nxt;
    logic                  r_dir;
    logic                  w_dir_nxt;
    logic                  r_bounce;
    logic                  w_bounce_nxt;
    logic                  r_step;
    logic                  w_step_nxt;
    logic                  r_load;
    logic                  w_load_nxt;
    logic                  w_running;
    logic                  w_unused_sw;

    assign w_unused_sw = ^i_sw;

    // Button synchronisers and edge detectors; r_arm masks the edges that appear
    // while the chain refills after reset, so a button held through release is ignored.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
            r_prev  <= 4'b0000;
            r_arm   <= 2'd0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_arm != 2'd3) begin
                r_arm <= r_arm + 2'd1;
            end else begin
                r_arm <= r_arm;
            end
        end
    end

    assign w_ev = (r_arm == 2'd3) ? (r_sync2 & ~r_prev) : 4'b0000;

    // Prescaler terminal count selected by the speed switches.
    always_comb begin
        case (i_sw[2:1])
            2'd0:    w_limit = LIM0;
            2'd1:    w_limit = LIM1;
            2'd2:    w_limit = LIM2;
            2'd3:    w_limit = LIM3;
            default: w_limit = LIM0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath: stop beats pause beats start; any event suppresses the tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_pos_nxt    = r_pos;
        w_dir_nxt    = r_dir;
        w_bounce_nxt = r_bounce ^ w_ev[3];
        w_step_nxt   = 1'b0;
        w_load_nxt   = 1'b0;
        w_running    = (r_state == ST_RUN_L) || (r_state == ST_RUN_R);
        if (w_ev[2]) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = {NB_COUNT{1'b0}};
            w_pos_nxt   = POS_ZERO;
            w_dir_nxt   = 1'b1;
            w_load_nxt  = 1'b1;
        end else if (w_ev[1]) begin
            case (r_state)
                ST_RUN_L, ST_RUN_R: w_state_nxt = ST_PAUSE;
                ST_PAUSE:           w_state_nxt = r_dir ? ST_RUN_L : ST_RUN_R;
                default:            w_state_nxt = r_state;
            endcase
        end else if (w_ev[0]) begin
            case (r_state)
                ST_IDLE, ST_RUN_R: begin
                    w_state_nxt = ST_RUN_L;
                    w_dir_nxt   = 1'b1;
                end
                ST_RUN_L: begin
                    w_state_nxt = ST_RUN_R;
                    w_dir_nxt   = 1'b0;
                end
                default: w_state_nxt = r_state;
            endcase
        end else if (w_running && i_sw[0]) begin
            if (r_count >= w_limit) begin
                w_count_nxt = {NB_COUNT{1'b0}};
                w_step_nxt  = 1'b1;
                if (r_state == ST_RUN_L) begin
                    if (r_bounce && (r_pos == POS_MAX)) begin
                        w_pos_nxt   = POS_MAX - POS_ONE;
                        w_dir_nxt   = 1'b0;
                        w_state_nxt = ST_RUN_R;
                    end else begin
                        w_pos_nxt   = (r_pos == POS_MAX) ? POS_ZERO : r_pos + POS_ONE;
                        w_dir_nxt   = 1'b1;
                    end
                end else begin
                    if (r_bounce && (r_pos == POS_ZERO)) begin
                        w_pos_nxt   = POS_ONE;
                        w_dir_nxt   = 1'b1;
                        w_state_nxt = ST_RUN_L;
                    end else begin
                        w_pos_nxt   = (r_pos == POS_ZERO) ? POS_MAX : r_pos - POS_ONE;
                        w_dir_nxt   = 1'b0;
                    end
                end
            end else begin
                w_count_nxt = r_count + NB_COUNT'(1);
            end
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Datapath and registered output pulses.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count  <= {NB_COUNT{1'b0}};
            r_pos    <= POS_ZERO;
            r_dir    <= 1'b1;
            r_bounce <= 1'b0;
            r_step   <= 1'b0;
            r_load   <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_pos    <= w_pos_nxt;
            r_dir    <= w_dir_nxt;
            r_bounce <= w_bounce_nxt;
            r_step   <= w_step_nxt;
            r_load   <= w_load_nxt;
        end
    end

    assign o_step   = r_step;
    assign o_dir    = r_dir;
    assign o_load   = r_load;
    assign o_seed   = N_LEDS'(1);
    assign o_state  = r_state;
    assign o_pos    = r_pos;
    assign o_bounce = r_bounce;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomised and directed bench for shift_seq_ctrl against a behavioural model
// that works from button sample history and plain position arithmetic.
module tb_shift_seq_ctrl;

    localparam int N_LEDS   = 4;
    localparam int NB_COUNT = 12;
    localparam int NB_SW    = 4;

    logic              clock;
    logic              i_reset;
    logic [NB_SW-1:0]  i_sw;
    logic [3:0]        i_btn;
    logic              o_step;
    logic              o_dir;
    logic              o_load;
    logic [N_LEDS-1:0] o_seed;
    logic [1:0]        o_state;
    logic [1:0]        o_pos;
    logic              o_bounce;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    int         m_state, m_cnt, m_pos, m_dir, m_bounce, m_step, m_load, m_nsamp;
    logic [3:0] m_h1, m_h2, m_h3;
    logic [11:0] act_v, exp_v;

    shift_seq_ctrl #(.N_LEDS(N_LEDS), .NB_COUNT(NB_COUNT), .NB_SW(NB_SW)) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_sw     (i_sw),
        .i_btn    (i_btn),
        .o_step   (o_step),
        .o_dir    (o_dir),
        .o_load   (o_load),
        .o_seed   (o_seed),
        .o_state  (o_state),
        .o_pos    (o_pos),
        .o_bounce (o_bounce)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int limit_of(input int sel);
        return (1 << (NB_COUNT - 10 + sel)) - 1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_pos = 0; m_dir = 1; m_bounce = 0;
        m_step = 0; m_load = 0; m_nsamp = 0;
        m_h1 = 4'b0000; m_h2 = 4'b0000; m_h3 = 4'b0000;
    endtask

    // A rise seen in the sample taken two edges ago acts now; samples are only
    // trusted once three have been taken since reset.
    task automatic model_edge();
        logic [3:0] ev;
        int d;
        ev = (m_nsamp >= 3) ? (m_h2 & ~m_h3) : 4'b0000;
        m_h3 = m_h2; m_h2 = m_h1; m_h1 = i_btn;
        if (m_nsamp < 3) m_nsamp++;
        m_step = 0; m_load = 0;
        if (ev[3]) m_bounce = 1 - m_bounce;
        if (ev[2]) begin
            m_state = 0; m_cnt = 0; m_pos = 0; m_dir = 1; m_load = 1;
        end else if (ev[1]) begin
            if (m_state == 1 || m_state == 2) m_state = 3;
            else if (m_state == 3) m_state = (m_dir == 1) ? 1 : 2;
        end else if (ev[0]) begin
            if (m_state != 3) begin
                m_dir   = (m_state == 1) ? 0 : 1;
                m_state = (m_dir == 1) ? 1 : 2;
            end
        end else if ((m_state == 1 || m_state == 2) && i_sw[0]) begin
            if (m_cnt >= limit_of(int'(i_sw[2:1]))) begin
                m_cnt  = 0;
                m_step = 1;
                d = (m_state == 1) ? 1 : -1;
                if (m_bounce == 1 && (m_pos + d < 0 || m_pos + d >= N_LEDS)) d = -d;
                m_pos   = (m_pos + d + N_LEDS) % N_LEDS;
                m_dir   = (d > 0) ? 1 : 0;
                m_state = (d > 0) ? 1 : 2;
            end else begin
                m_cnt++;
            end
        end
    endtask

    initial forever begin
        @(posedge clock or negedge i_reset);
        if (!i_reset) model_reset();
        else model_edge();
    end

    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            act_v = {o_step, o_dir, o_load, o_state, o_pos, o_bounce, o_seed};
            exp_v = {m_step[0], m_dir[0], m_load[0], m_state[1:0], m_pos[1:0], m_bounce[0], 4'b0001};
            check("outputs_vs_model", int'(act_v), int'(exp_v));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input int b);
        i_btn[b] = 1'b1;
        tick(3);
        i_btn[b] = 1'b0;
        tick(2);
    endtask

    task automatic wait_step(output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (o_step != 1'b1 && cyc < 300);
        check("step_seen", int'(o_step), 1);
    endtask

    initial begin
        int c;
        int loads;
        int steps;
        int pos_saved;
        int sel;
        int exp_pos[7];
        int exp_st[7];
        exp_pos = '{1, 2, 3, 2, 1, 0, 1};
        exp_st  = '{1, 1, 1, 2, 2, 2, 1};
        model_reset();
        i_reset = 1'b0;
        i_sw    = 4'b0001;
        i_btn   = 4'b0000;
        tick(3);
        cmp_en = 1'b1;
        @(negedge clock);
        check("reset_state", int'(o_state), 0);
        check("reset_pos", int'(o_pos), 0);
        check("reset_dir", int'(o_dir), 1);
        check("reset_step", int'(o_step), 0);
        check("reset_load", int'(o_load), 0);
        check("reset_bounce", int'(o_bounce), 0);
        check("seed", int'(o_seed), 1);
        @(posedge clock); #1;
        i_reset = 1'b1;
        tick(4);

        // R0=3: step every 4 cycles, position walks 1,2,3,0
        press(0);
        check("start_run_l", int'(o_state), 1);
        for (int i = 0; i < 4; i++) begin
            wait_step(c);
            if (i > 0) check("r0_period", c, 4);
            check("r0_pos", int'(o_pos), (i + 1) % 4);
        end

        // R3=31 gives a 32-cycle period; dropping to R0 with counter>3 steps next cycle
        i_sw = 4'b0111;
        wait_step(c);
        wait_step(c);
        check("r3_period", c, 32);
        repeat (10) @(negedge clock);
        i_sw = 4'b0001;
        wait_step(c);
        check("limit_drop_latency", c, 1);

        // stop, bounce on, run: 1,2,3,2,1,0,1
        press(2);
        check("stop_state", int'(o_state), 0);
        check("stop_pos", int'(o_pos), 0);
        check("stop_dir", int'(o_dir), 1);
        press(3);
        check("bounce_on", int'(o_bounce), 1);
        press(0);
        check("bounce_start", int'(o_state), 1);
        for (int i = 0; i < 7; i++) begin
            wait_step(c);
            check("bounce_pos", int'(o_pos), exp_pos[i]);
            check("bounce_state", int'(o_state), exp_st[i]);
        end

        // reverse to RUN_R (steps to pos 0), then pause with counter at 2
        press(0);
        wait_step(c);
        check("rev_pos", int'(o_pos), 0);
        check("rev_state", int'(o_state), 2);
        i_btn[1] = 1'b1;
        repeat (3) @(negedge clock);
        i_btn[1] = 1'b0;
        check("pause_state", int'(o_state), 3);
        pos_saved = int'(o_pos);
        steps = 0;
        repeat (100) begin
            @(negedge clock);
            steps += int'(o_step);
        end
        check("pause_no_step", steps, 0);
        check("pause_pos_hold", int'(o_pos), pos_saved);
        check("pause_dir_hold", int'(o_dir), 0);
        i_btn[1] = 1'b1;
        c = 0;
        do begin
            @(negedge clock);
            c++;
            if (c == 3) begin
                i_btn[1] = 1'b0;
                check("resume_state", int'(o_state), 2);
            end
        end while (o_step != 1'b1 && c < 300);
        check("resume_preserved_count", c, 5);
        check("resume_bounce_pos", int'(o_pos), 1);
        check("resume_bounce_state", int'(o_state), 1);

        // btn0/1/2 together during RUN_L: stop wins, single load
        i_btn = 4'b0111;
        loads = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            loads += int'(o_load);
            if (i == 2) i_btn = 4'b0000;
        end
        check("multi_load_count", loads, 1);
        check("multi_state", int'(o_state), 0);
        check("multi_pos", int'(o_pos), 0);
        check("multi_dir", int'(o_dir), 1);

        // async reset mid-run at pos 2 with bounce on; btn0 held through release
        press(0);
        wait_step(c);
        wait_step(c);
        check("pre_reset_pos", int'(o_pos), 2);
        #2;
        i_reset = 1'b0;
        i_btn   = 4'b0001;
        #1;
        check("async_state", int'(o_state), 0);
        check("async_pos", int'(o_pos), 0);
        check("async_dir", int'(o_dir), 1);
        check("async_bounce", int'(o_bounce), 0);
        check("async_step", int'(o_step), 0);
        tick(3);
        i_reset = 1'b1;
        loads = 0;
        repeat (12) begin
            @(negedge clock);
            loads += int'(o_load);
        end
        check("release_no_event", int'(o_state), 0);
        check("release_no_load", loads, 0);
        i_btn = 4'b0000;
        tick(4);

        // randomised traffic, checked every cycle by the model
        for (int k = 0; k < 4000; k++) begin
            @(posedge clock); #1;
            if ($urandom_range(0, 11) == 0) begin
                sel = $urandom_range(0, 9);
                if (sel < 4) i_btn = i_btn ^ 4'b0001;
                else if (sel < 6) i_btn = i_btn ^ 4'b0010;
                else if (sel < 7) i_btn = i_btn ^ 4'b0100;
                else i_btn = i_btn ^ 4'b1000;
            end
            if ($urandom_range(0, 99) == 0)
                i_sw = {1'b0, 2'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0)};
            if ($urandom_range(0, 1999) == 0) begin
                #2;
                i_reset = 1'b0;
                #4;
                i_reset = 1'b1;
            end
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter N_LEDS, default 4: width of the controlled LED shift register.
REQ-002 Parameter NB_COUNT, default 32: prescaler counter width; the bench uses NB_COUNT=12.
REQ-003 Parameter NB_SW, default 4: switch bus width.
REQ-004 clock  input  1  system clock; single clock domain, all state on its rising edge.
REQ-005 i_reset  input  1  reset, asynchronous, active-low.
REQ-006 i_sw  input  NB_SW  switches: bit 0 = run enable; bits [2:1] = speed select.
REQ-007 i_btn  input  4  raw asynchronous buttons: 0 = start/reverse, 1 = pause/resume, 2 = stop/reload, 3 = bounce toggle.
REQ-008 o_step  output  1  one-cycle pulse: downstream register shifts one position.
REQ-009 o_dir  output  1  shift direction, valid with o_step: 1 = left (toward MSB), 0 = right.
REQ-010 o_load  output  1  one-cycle pulse: downstream register loads o_seed.
REQ-011 o_seed  output  N_LEDS  constant seed, LSB = 1, all other bits 0.
REQ-012 o_state  output  2  FSM state: 0 IDLE, 1 RUN_L, 2 RUN_R, 3 PAUSE.
REQ-013 o_pos  output  ceil(log2(N_LEDS))  index of the lit LED.
REQ-014 o_bounce  output  1  bounce mode active.

Function
REQ-015 Each i_btn bit SHALL pass a 2-flop synchronizer followed by rising-edge detection; a raw rise before edge k SHALL update state at edge k+2; holding a button SHALL yield exactly one event.
REQ-016 Speed limit SHALL be R0..R3 = 2^(NB_COUNT-10)-1, 2^(NB_COUNT-9)-1, 2^(NB_COUNT-8)-1, 2^(NB_COUNT-7)-1 for i_sw[2:1] = 0..3; limit changes SHALL take effect immediately.
REQ-017 Prescaler SHALL increment only in RUN_L/RUN_R with i_sw[0]=1; when count >= limit it SHALL clear to 0 and assert o_step for that cycle.
REQ-018 i_sw[0]=0 SHALL freeze counter, o_pos and state; button events SHALL still be processed.
REQ-019 IDLE: btn0 -> RUN_L with o_dir=1. RUN_L/RUN_R: btn0 -> opposite RUN state. RUN_x: btn1 -> PAUSE, remembering direction. PAUSE: btn1 -> remembered RUN state. Any state: btn2 -> IDLE.
REQ-020 Simultaneous events: btn2 > btn1 > btn0; only the highest-priority of these SHALL act; btn3 SHALL act independently in the same cycle.
REQ-021 btn3 SHALL toggle o_bounce in any state.
REQ-022 Entering IDLE via btn2 SHALL clear the counter, set o_pos=0 and o_dir=1, and pulse o_load for one cycle; o_step SHALL be 0 in that cycle.
REQ-023 PAUSE SHALL hold counter and o_pos; no o_step SHALL occur in IDLE or PAUSE.
REQ-024 On o_step, o_pos SHALL become (o_pos+1) mod N_LEDS for left and (o_pos-1) mod N_LEDS for right.
REQ-025 Bounce mode: a step due in RUN_L at o_pos=N_LEDS-1 SHALL issue o_step with o_dir=0, set o_pos=N_LEDS-2 and state RUN_R; symmetrically, RUN_R at o_pos=0 SHALL step left to 1 and enter RUN_L.
REQ-026 o_dir SHALL equal 1 in RUN_L and 0 in RUN_R, and SHALL retain its value in PAUSE.
REQ-027 A direction reversal by btn0 SHALL preserve the counter value.

Reset
REQ-028 While i_reset=0: state IDLE, counter 0, o_pos 0, o_dir 1, o_bounce 0, o_step 0, o_load 0, synchronizer flops 0.
REQ-029 Reset assertion SHALL take effect asynchronously mid-operation; release SHALL cause no o_step, o_load or button event.

Verification
REQ-030 NB_COUNT=12, i_sw=0001 (R0=3), btn0 pulse -> RUN_L; o_step every 4 cycles, o_pos 0,1,2,3,0.
REQ-031 i_sw[2:1]=3 (R3=31) -> o_step period 32 cycles; switch to 0 mid-count with counter>3 -> o_step on the next cycle.
REQ-032 Bounce on, RUN_L from o_pos 0 -> o_pos 1,2,3,2,1,0,1; o_state flips to 2 on the step that leaves o_pos=3.
REQ-033 RUN_R, btn1 -> PAUSE, no o_step for 100 cycles; btn1 -> RUN_R resumes with the preserved counter.
REQ-034 btn0, btn1, btn2 rise in the same cycle during RUN_L -> IDLE, single o_load pulse, o_pos=0, o_dir=1.
REQ-035 i_reset=0 mid-RUN with o_pos=2, bounce on -> all outputs at reset values immediately; held btn0 during release -> no event.
